// File: rtl/mux_rr_pipe.sv
// N-to-1 data-path multiplexer with valid/ready on every input and on the output,
// selectable fixed-select or round-robin arbitration, and one registered output stage.
module mux_rr_pipe #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_IN     = 4,
  localparam int SEL_WIDTH  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ARB_MODE,
  input  logic [SEL_WIDTH-1:0]         SEL,
  input  logic [NUM_IN*DATA_WIDTH-1:0] IN_DATA,
  input  logic [NUM_IN-1:0]            IN_VALID,
  output logic [NUM_IN-1:0]            IN_READY,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic [SEL_WIDTH-1:0]         OUT_SRC,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY
);

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  // SEL can address up to 2**SEL_WIDTH channels; the padding entries are never valid.
  localparam int EXT_IN = 1 << SEL_WIDTH;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_src_q,  out_src_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_WIDTH-1:0]  rr_ptr_q,   rr_ptr_d;

  arb_mode_e             mode;
  logic [EXT_IN-1:0]     valid_ext;
  logic                  load_en;
  logic                  grant_valid;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] grant_data;

  assign mode    = arb_mode_e'(ARB_MODE);
  assign load_en = !out_valid_q || OUT_READY;

  // Grant selection: fixed index in fixed mode, first valid channel at or after the pointer in RR mode.
  always_comb begin
    int cand;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    valid_ext              = '0;
    valid_ext[NUM_IN-1:0]  = IN_VALID;
    grant_valid            = 1'b0;
    grant_idx              = '0;
    cand                   = 0;
    if (mode == MODE_FIXED) begin
      grant_valid = valid_ext[SEL];
      grant_idx   = SEL;
    end else begin
      for (int off = 0; off < NUM_IN; off++) begin
        cand = int'(rr_ptr_q) + off;
        if (cand >= NUM_IN) cand = cand - NUM_IN;
        if (!grant_valid && IN_VALID[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_WIDTH'(cand);
        end
      end
    end
  end

  assign transfer = RST && load_en && grant_valid;

  // Decoded data mux and one-hot ready; out-of-range indices match no channel.
  always_comb begin
    grant_data = '0;
    IN_READY   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant_idx == SEL_WIDTH'(k)) begin
        grant_data  = IN_DATA[k*DATA_WIDTH +: DATA_WIDTH];
        IN_READY[k] = transfer;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (transfer) begin
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = (grant_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0 : grant_idx + SEL_WIDTH'(1);
      end
    end else if (load_en) begin
      // Consumer drained the beat (or stage was empty) and nothing new arrived.
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_SRC   = out_src_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: doc/mux_rr_pipe.md
Name: mux_rr_pipe

Overview:
- Parametrised N-to-1 data-path multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the fixed-width combinational muxes: adds a selectable arbitration mode (fixed select or round-robin) and one registered output stage.
- Sits between multiple producers (register-file read ports, ALU result sources, memory return) and a single consumer in the processor data path.

Parameters:
- DATA_WIDTH, 32, bit width of each data channel.
- NUM_IN, 4, number of input channels; legal range 2..32, power of two not required.
- SEL_WIDTH, derived = ceil(log2(NUM_IN)), not overridable, width of SEL and OUT_SRC.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous active-low reset.
- ARB_MODE  in  1  0 = fixed select via SEL; 1 = round-robin.
- SEL  in  SEL_WIDTH  channel index used when ARB_MODE=0.
- IN_DATA  in  NUM_IN*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- IN_VALID  in  NUM_IN  per-channel valid.
- IN_READY  out  NUM_IN  per-channel ready; at most one bit high at a time.
- OUT_DATA  out  DATA_WIDTH  registered selected data.
- OUT_SRC  out  SEL_WIDTH  index of the channel that produced OUT_DATA.
- OUT_VALID  out  1  output holds a beat.
- OUT_READY  in  1  consumer accepts the beat.

Behaviour:
- Reset (RST=0, asynchronous assert, synchronous release): OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, RR pointer=0. IN_READY is forced to 0 while RST=0.
- load_en = !OUT_VALID || OUT_READY. This gives full throughput: one beat per cycle when the consumer is always ready.
- Grant, fixed mode: grant is SEL when SEL < NUM_IN and IN_VALID[SEL]=1; otherwise no grant. An out-of-range SEL never grants and never asserts IN_READY.
- Grant, round-robin mode: grant is the first k with IN_VALID[k]=1, searching from the pointer upward and wrapping modulo NUM_IN. No grant if IN_VALID is all 0.
- IN_READY[g] = load_en && grant valid && g is the granted index. All other IN_READY bits are 0. IN_READY is combinational from the current inputs and state.
- On a transfer (IN_VALID[g] && IN_READY[g]), at the clock edge:
  - OUT_DATA <= channel g data, OUT_SRC <= g, OUT_VALID <= 1.
  - In RR mode only, pointer <= (g+1) mod NUM_IN, including the wrap from NUM_IN-1 to 0.
- Latency: input accepted in cycle t appears on OUT_* in cycle t+1.
- load_en=1 with no transfer: OUT_VALID <= 0. OUT_DATA and OUT_SRC keep their last values.
- Backpressure (OUT_VALID=1, OUT_READY=0): OUT_DATA, OUT_SRC and OUT_VALID hold stable; all IN_READY=0; pointer holds.
- Simultaneous drain and refill (OUT_VALID=1, OUT_READY=1, new grant): the old beat is consumed and the new beat loads in the same edge, with no bubble.
- Pointer is retained while in fixed mode. ARB_MODE and SEL changes take effect in the same cycle's grant; no beat in flight is altered.
- Reset asserted mid-operation: the output beat is discarded immediately and OUT_VALID drops asynchronously.
- Inputs are not stored. A producer must hold IN_DATA and IN_VALID until IN_READY is seen.

Test Plan:
- Reset: drive RST=0 with all IN_VALID=1 -> OUT_VALID=0, OUT_DATA=0, IN_READY=0; release RST with ARB_MODE=1 -> first grant is channel 0, and OUT_SRC=0 one cycle later.
- Fixed mode, NUM_IN=4: SEL=2, IN_DATA ch2=0xDEADBEEF, all valid, OUT_READY=1 -> IN_READY=4'b0100; next cycle OUT_DATA=0xDEADBEEF, OUT_SRC=2. Then SEL=3 with IN_VALID[3]=0 -> IN_READY=0, and OUT_VALID=0 next cycle.
- Round-robin fairness: all 4 channels valid continuously, OUT_READY=1 -> OUT_SRC sequence 0,1,2,3,0,1 on consecutive cycles, with OUT_VALID high throughout.
- Sparse RR with wrap: pointer=3, only ch1 and ch3 valid -> ch3 granted, then ch1, then ch3. With NUM_IN=5, pointer 4 -> grant ch4, then pointer wraps to 0.
- Backpressure: after a beat 0x11 from ch0 loads, hold OUT_READY=0 for 3 cycles -> OUT_DATA stays 0x11, all IN_READY=0, pointer unchanged. Raise OUT_READY -> the next beat loads on the same edge the old beat drains.
- Mid-stream reset: assert RST=0 while OUT_VALID=1 -> OUT_VALID=0 immediately, without waiting for a clock edge; after release, RR restarts from channel 0.
